mem_req_arbiter: RTL and testbench
==================================

Name: mem_req_arbiter

Overview:
- Consumer stage for two request FIFOs: the instruction-cache miss FIFO (client 0) and the data-cache miss/evict FIFO (client 1).
- Pops one request at a time using round-robin arbitration and drives it onto the single main-memory port with a valid/ready handshake.
- Waits for the memory response, with a timeout, then returns the response to the originating client.
- Sits between the per-cache FIFOs and the main-memory model.

Parameters:
ADDR_W, 32, request address width
LINE_W, 128, cache line data width
REQ_W, 1+ADDR_W+LINE_W, request word width: {is_write, addr, wdata} with is_write at the MSB
TIMEOUT, 64, maximum cycles spent in WAIT before a forced error response (≥2)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
c0_not_empty  in  1  client-0 FIFO holds an entry
c0_rdata  in  REQ_W  client-0 FIFO head entry, valid while c0_not_empty
c0_pop  out  1  pop client-0 FIFO
c1_not_empty  in  1  client-1 FIFO holds an entry
c1_rdata  in  REQ_W  client-1 FIFO head entry
c1_pop  out  1  pop client-1 FIFO
mem_req_valid  out  1  request presented to memory
mem_req_ready  in  1  memory accepts the request
mem_req_write  out  1  request is a write
mem_req_addr  out  ADDR_W  request address
mem_req_wdata  out  LINE_W  write data
mem_rsp_valid  in  1  memory response strobe, one cycle
mem_rsp_rdata  in  LINE_W  read data
c0_rsp_valid  out  1  response strobe to client 0
c1_rsp_valid  out  1  response strobe to client 1
rsp_rdata  out  LINE_W  response data, shared by both clients
rsp_err  out  1  response was a timeout
err_timeout  out  1  sticky timeout flag

Behaviour:
- Reset is asynchronous, active-high. On reset:
  - state = IDLE; all outputs = 0; err_timeout = 0.
  - last_grant = 1, so client 0 wins the first tie.
  - Reset asserted mid-transaction aborts it. No response is issued, and a popped request is lost.
- FSM states: IDLE, REQ, WAIT, RSP.
- IDLE:
  - If neither not_empty is high, stay in IDLE.
  - If exactly one not_empty is high, grant that client.
  - If both are high, grant the client != last_grant.
  - In the same cycle: assert that client's pop for exactly one cycle, capture its rdata into the request register, record the grant as last_grant and cur_client, and go to REQ.
- REQ:
  - mem_req_valid = 1; mem_req_write, addr and wdata are driven from the request register and held stable until accepted.
  - On mem_req_ready: clear the timeout counter and go to WAIT.
  - No timeout applies in REQ.
- WAIT:
  - mem_req_valid = 0. The counter increments every cycle.
  - On mem_rsp_valid: capture mem_rsp_rdata, set rsp_err_next = 0, go to RSP.
  - Otherwise, if the counter == TIMEOUT-1: set captured data = 0, rsp_err_next = 1, set err_timeout, go to RSP.
  - If mem_rsp_valid arrives on the timeout cycle, the response wins.
- RSP:
  - For exactly one cycle, assert c{cur_client}_rsp_valid, with rsp_rdata and rsp_err taken from the registers.
  - For writes, rsp_rdata = 0 (data ignored); the strobe serves as the write acknowledgement.
  - Go to IDLE.
- rsp_rdata and rsp_err are 0 outside RSP.
- mem_rsp_valid outside WAIT is ignored. A late response after a timeout is dropped.
- No pop is ever issued when the corresponding not_empty is low. At most one pop per transaction.
- Latency: pop at cycle t, mem_req_valid from t+1. With ready at t+1 and response at t+2, rsp_valid is at t+3. Minimum 4 cycles per transaction.
- err_timeout is sticky and cleared only by reset.
- The counter is $clog2(TIMEOUT) bits wide and never wraps past TIMEOUT-1.

Test Plan:
- Single read, client 0 (is_write=0, addr=0x100): pop at t; mem_req_valid t+1; ready t+1; rsp at t+2 with 0xDEAD…; → c0_rsp_valid at t+3, rsp_rdata=0xDEAD…, rsp_err=0.
- Both FIFOs hold 2 entries each from reset → grant order c0, c1, c0, c1; each pop exactly one cycle; no response misrouted.
- Backpressure: mem_req_ready low for 5 cycles → mem_req_valid/addr/wdata stable for all 6 cycles; single pop only.
- Timeout with TIMEOUT=64 and no mem_rsp_valid → after 64 WAIT cycles: c1_rsp_valid=1, rsp_rdata=0, rsp_err=1, err_timeout=1 sticky. A later stray mem_rsp_valid is ignored.
- Write from client 1 (is_write=1, wdata=0x1234) → mem_req_write=1, mem_req_wdata=0x1234; after the response, c1_rsp_valid=1 with rsp_rdata=0.
- Reset pulsed during WAIT → all outputs 0 immediately (asynchronous); no rsp_valid; next arbitration grants client 0 when both are pending.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// Round-robin consumer for the I-cache and D-cache miss FIFOs: pops one request,
// drives it onto the main-memory port, waits (with timeout) and routes the response back.
module mem_req_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned LINE_W  = 128,
  parameter int unsigned REQ_W   = 1 + ADDR_W + LINE_W,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              c0_not_empty,
  input  logic [REQ_W-1:0]  c0_rdata,
  output logic              c0_pop,
  input  logic              c1_not_empty,
  input  logic [REQ_W-1:0]  c1_rdata,
  output logic              c1_pop,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_write,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [LINE_W-1:0] mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [LINE_W-1:0] mem_rsp_rdata,
  output logic              c0_rsp_valid,
  output logic              c1_rsp_valid,
  output logic [LINE_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              err_timeout
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StRsp} state_e;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              cur_client_q, cur_client_d;
  logic [REQ_W-1:0]  req_q, req_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              err_timeout_q, err_timeout_d;
  logic              grant;

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    cur_client_d  = cur_client_q;
    req_d         = req_q;
    cnt_d         = cnt_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    err_timeout_d = err_timeout_q;
    c0_pop        = 1'b0;
    c1_pop        = 1'b0;
    mem_req_valid = 1'b0;
    c0_rsp_valid  = 1'b0;
    c1_rsp_valid  = 1'b0;
    // On a tie the client that did not win last time goes next.
    grant = (c0_not_empty && c1_not_empty) ? ~last_grant_q : c1_not_empty;

    unique case (state_q)
      StIdle: begin
        if (c0_not_empty || c1_not_empty) begin
          // Pops are combinational, so hold them off while reset is asserted.
          c0_pop       = ~grant & ~reset;
          c1_pop       = grant & ~reset;
          req_d        = grant ? c1_rdata : c0_rdata;
          last_grant_d = grant;
          cur_client_d = grant;
          state_d      = StReq;
        end
      end
      StReq: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          cnt_d   = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (mem_rsp_valid) begin
          rdata_d = req_q[REQ_W-1] ? '0 : mem_rsp_rdata;
          err_d   = 1'b0;
          state_d = StRsp;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          rdata_d       = '0;
          err_d         = 1'b1;
          err_timeout_d = 1'b1;
          state_d       = StRsp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRsp: begin
        c0_rsp_valid = ~cur_client_q;
        c1_rsp_valid = cur_client_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_req_write = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    rsp_rdata     = '0;
    rsp_err       = 1'b0;
    if (state_q == StReq) begin
      mem_req_write = req_q[REQ_W-1];
      mem_req_addr  = req_q[REQ_W-2 -: ADDR_W];
      mem_req_wdata = req_q[LINE_W-1:0];
    end
    if (state_q == StRsp) begin
      rsp_rdata = rdata_q;
      rsp_err   = err_q;
    end
    err_timeout = err_timeout_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      last_grant_q  <= 1'b1;
      cur_client_q  <= 1'b0;
      req_q         <= '0;
      cnt_q         <= '0;
      rdata_q       <= '0;
      err_q         <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      cur_client_q  <= cur_client_d;
      req_q         <= req_d;
      cnt_q         <= cnt_d;
      rdata_q       <= rdata_d;
      err_q         <= err_d;
      err_timeout_q <= err_timeout_d;
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: two FIFO models feed the DUT, memory is driven by hand.
module tb_mem_req_arbiter;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned LINE_W  = 128;
  localparam int unsigned REQ_W   = 1 + ADDR_W + LINE_W;
  localparam int unsigned TIMEOUT = 64;

  logic              clock;
  logic              reset;
  logic              c0_not_empty, c1_not_empty;
  logic [REQ_W-1:0]  c0_rdata, c1_rdata;
  logic              c0_pop, c1_pop;
  logic              mem_req_valid, mem_req_ready, mem_req_write;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [LINE_W-1:0] mem_req_wdata;
  logic              mem_rsp_valid;
  logic [LINE_W-1:0] mem_rsp_rdata;
  logic              c0_rsp_valid, c1_rsp_valid;
  logic [LINE_W-1:0] rsp_rdata;
  logic              rsp_err, err_timeout;

  int n_cmp = 0;
  int n_bad = 0;

  // FIFO models: entries written by the stimulus, head pointers advanced by DUT pops.
  logic [REQ_W-1:0] f0 [4];
  logic [REQ_W-1:0] f1 [4];
  int               n0, n1, h0, h1;
  logic             fifo_clr;

  assign c0_not_empty = (h0 < n0);
  assign c1_not_empty = (h1 < n1);
  assign c0_rdata     = f0[h0[1:0]];
  assign c1_rdata     = f1[h1[1:0]];

  always @(posedge clock or posedge fifo_clr) begin
    if (fifo_clr) begin
      h0 <= 0;
      h1 <= 0;
    end else begin
      if (c0_pop) h0 <= h0 + 1;
      if (c1_pop) h1 <= h1 + 1;
    end
  end

  mem_req_arbiter #(
    .ADDR_W (ADDR_W),
    .LINE_W (LINE_W),
    .REQ_W  (REQ_W),
    .TIMEOUT(TIMEOUT)
  ) u_dut (
    .clock        (clock),
    .reset        (reset),
    .c0_not_empty (c0_not_empty),
    .c0_rdata     (c0_rdata),
    .c0_pop       (c0_pop),
    .c1_not_empty (c1_not_empty),
    .c1_rdata     (c1_rdata),
    .c1_pop       (c1_pop),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write),
    .mem_req_addr (mem_req_addr),
    .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_rdata(mem_rsp_rdata),
    .c0_rsp_valid (c0_rsp_valid),
    .c1_rsp_valid (c1_rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .err_timeout  (err_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [REQ_W-1:0] mk(input logic wr, input logic [ADDR_W-1:0] a,
                                          input logic [LINE_W-1:0] d);
    return {wr, a, d};
  endfunction

  // Leaves reset asserted with empty FIFOs; caller loads entries and releases reset.
  task automatic do_reset();
    @(negedge clock);
    reset         = 1'b1;
    fifo_clr      = 1'b1;
    n0            = 0;
    n1            = 0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;
    repeat (2) @(negedge clock);
    fifo_clr = 1'b0;
  endtask

  task automatic release_reset();
    #1;
    check_eq("pop_in_reset", {c1_pop, c0_pop}, 2'b00);
    check_eq("valid_in_reset", mem_req_valid, 1'b0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Called at a negedge with the DUT in IDLE and the expected winner pending.
  task automatic run_txn(input int cl, input logic [ADDR_W-1:0] addr, input logic wr,
                         input logic [LINE_W-1:0] wdata, input int stall,
                         input logic [LINE_W-1:0] mem_data, input logic [LINE_W-1:0] exp_rd);
    logic [1:0] sel;
    sel = (cl == 1) ? 2'b10 : 2'b01;
    #1;
    check_eq("pop_sel", {c1_pop, c0_pop}, sel);
    @(negedge clock);
    for (int i = 0; i <= stall; i++) begin
      check_eq("req_valid", mem_req_valid, 1'b1);
      check_eq("req_addr", mem_req_addr, addr);
      check_eq("req_write", mem_req_write, wr);
      check_eq("req_wdata", mem_req_wdata, wdata);
      check_eq("pop_in_req", {c1_pop, c0_pop}, 2'b00);
      mem_req_ready = (i == stall);
      @(negedge clock);
    end
    mem_req_ready = 1'b0;
    check_eq("valid_in_wait", mem_req_valid, 1'b0);
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = mem_data;
    @(negedge clock);
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;
    check_eq("rsp_route", {c1_rsp_valid, c0_rsp_valid}, sel);
    check_eq("rsp_rdata", rsp_rdata, exp_rd);
    check_eq("rsp_err", rsp_err, 1'b0);
    @(negedge clock);
    check_eq("rsp_one_cycle", {c1_rsp_valid, c0_rsp_valid}, 2'b00);
    check_eq("rdata_idle", rsp_rdata, '0);
  endtask

  initial begin
    reset         = 1'b1;
    fifo_clr      = 1'b1;
    n0            = 0;
    n1            = 0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;

    // Single read from client 0, minimum latency.
    do_reset();
    f0[0] = mk(1'b0, 32'h100, '0);
    n0    = 1;
    check_eq("rst_err_timeout", err_timeout, 1'b0);
    check_eq("rst_rsp", {c1_rsp_valid, c0_rsp_valid, rsp_err}, 3'b000);
    release_reset();
    run_txn(0, 32'h100, 1'b0, '0, 0, {4{32'hDEAD_BEEF}}, {4{32'hDEAD_BEEF}});
    check_eq("t1_pops", h0, 1);

    // Round robin with both FIFOs holding two entries.
    do_reset();
    f0[0] = mk(1'b0, 32'h200, '0);
    f0[1] = mk(1'b0, 32'h210, '0);
    f1[0] = mk(1'b0, 32'h280, '0);
    f1[1] = mk(1'b0, 32'h290, '0);
    n0    = 2;
    n1    = 2;
    release_reset();
    run_txn(0, 32'h200, 1'b0, '0, 0, 128'hA0, 128'hA0);
    run_txn(1, 32'h280, 1'b0, '0, 0, 128'hA1, 128'hA1);
    run_txn(0, 32'h210, 1'b0, '0, 0, 128'hA2, 128'hA2);
    run_txn(1, 32'h290, 1'b0, '0, 0, 128'hA3, 128'hA3);
    check_eq("rr_pops", {h1[3:0], h0[3:0]}, 8'h22);

    // Backpressure: ready held low for five cycles.
    do_reset();
    f0[0] = mk(1'b0, 32'h500, 128'h5555);
    n0    = 1;
    release_reset();
    run_txn(0, 32'h500, 1'b0, 128'h5555, 5, 128'hC0FFEE, 128'hC0FFEE);
    check_eq("bp_pops", h0, 1);

    // Timeout on client 1, then a stray late response.
    do_reset();
    f1[0] = mk(1'b0, 32'h300, '0);
    n1    = 1;
    release_reset();
    #1;
    check_eq("to_pop", {c1_pop, c0_pop}, 2'b10);
    @(negedge clock);
    check_eq("to_req_valid", mem_req_valid, 1'b1);
    mem_req_ready = 1'b1;
    @(negedge clock);
    mem_req_ready = 1'b0;
    for (int i = 1; i < int'(TIMEOUT); i++) begin
      @(negedge clock);
      check_eq("to_wait_rsp", {c1_rsp_valid, c0_rsp_valid, err_timeout}, 3'b000);
    end
    @(negedge clock);
    check_eq("to_rsp_route", {c1_rsp_valid, c0_rsp_valid}, 2'b10);
    check_eq("to_rsp_rdata", rsp_rdata, '0);
    check_eq("to_rsp_err", rsp_err, 1'b1);
    check_eq("to_sticky_set", err_timeout, 1'b1);
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 128'hBAD;
    @(negedge clock);
    mem_rsp_valid = 1'b0;
    repeat (3) begin
      check_eq("late_rsp_drop", {c1_rsp_valid, c0_rsp_valid, mem_req_valid}, 3'b000);
      check_eq("to_sticky_hold", err_timeout, 1'b1);
      @(negedge clock);
    end

    // Write from client 1: data is sent, response data is zeroed.
    do_reset();
    check_eq("sticky_cleared", err_timeout, 1'b0);
    f1[0] = mk(1'b1, 32'h400, 128'h1234);
    n1    = 1;
    release_reset();
    run_txn(1, 32'h400, 1'b1, 128'h1234, 0, {4{32'hFFFF_FFFF}}, '0);

    // Reset during WAIT aborts; afterwards client 0 wins the tie again.
    do_reset();
    f0[0] = mk(1'b0, 32'h600, '0);
    n0    = 1;
    release_reset();
    run_txn(0, 32'h600, 1'b0, '0, 0, 128'h66, 128'h66);
    f0[1] = mk(1'b0, 32'h610, '0);
    f1[0] = mk(1'b0, 32'h700, '0);
    f1[1] = mk(1'b0, 32'h710, '0);
    n0    = 2;
    n1    = 2;
    #1;
    check_eq("pre_rst_pop", {c1_pop, c0_pop}, 2'b10);
    @(negedge clock);
    mem_req_ready = 1'b1;
    @(negedge clock);
    mem_req_ready = 1'b0;
    reset         = 1'b1;
    #1;
    check_eq("async_rst_ctl", {c1_pop, c0_pop, mem_req_valid, c1_rsp_valid, c0_rsp_valid},
             5'b00000);
    check_eq("async_rst_data", {rsp_err, err_timeout, mem_req_addr}, '0);
    @(negedge clock);
    check_eq("rst_no_rsp", {c1_rsp_valid, c0_rsp_valid}, 2'b00);
    reset = 1'b0;
    run_txn(0, 32'h610, 1'b0, '0, 0, 128'h77, 128'h77);
    check_eq("rst_lost_pop", {h1[3:0], h0[3:0]}, 8'h12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
